system_gpio_pio: RTL
====================

# system_gpio_pio

Parametrised Avalon-MM GPIO slave and successor to the fixed 8-bit output-only LED PIO. It adds:
- configurable width and reset value
- per-bit direction control
- atomic bit set/clear
- a synchronised input path with edge capture and a maskable interrupt

It sits on the system interconnect as a zero-wait-state slave beside the other PIOs and drives board-level LEDs, buttons and headers.

## Interface
- WIDTH, 8, number of GPIO bits (1..32)
- RESET_VALUE, 0, reset value of output data register (WIDTH bits)
- EDGE_MODE, 0, edge-capture polarity: 0 rising, 1 falling, 2 any

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  read data; bits above WIDTH read 0
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe_port  out  WIDTH  per-bit output enable (1 = drive)
- irq  out  1  level interrupt, active-high

## Operation
- Register map (write = chipselect & ~write_n):
  - 0 DATA: write loads data_out; read returns synchronised input (sync2)
  - 1 DIRECTION: R/W, drives oe_port
  - 2 IRQ_MASK: R/W
  - 3 EDGE_CAPTURE: read returns capture bits; write-1-to-clear
  - 4 OUTSET: write ORs writedata into data_out; read returns data_out
  - 5 OUTCLEAR: write clears data_out bits set in writedata; read returns data_out
  - 6, 7: writes ignored, reads 0
- Input path:
  - in_port -> sync1 -> sync2, two flops
  - prev register holds sync2 of the previous cycle
- Edge detect per bit:
  - rising: sync2 & ~prev
  - falling: ~sync2 & prev
  - any: sync2 ^ prev
- Detected edge sets the EDGE_CAPTURE bit; the bit holds until cleared.
- irq = |(edge_capture & irq_mask), driven from registers, glitch-free.
- Edge set and write-1-to-clear on the same bit in the same cycle: the set wins and the bit stays 1.
- out_port = data_out regardless of direction; oe_port is qualification only.
- Reset:
  - data_out = RESET_VALUE, so out_port = RESET_VALUE
  - direction, irq_mask, edge_capture, sync1, sync2, prev all 0
  - oe_port = 0, irq = 0
- Reset asserted mid-operation clears all state asynchronously. The first edge detection after release compares against prev = 0, so a pin held high after reset produces a rising capture 2 cycles after release.

## Timing
- Writes take effect at the clk edge where chipselect & ~write_n is sampled. out_port, oe_port and irq_mask change at that edge.
- Reads are combinational from address with zero wait states; readdata is valid in the same cycle.
- Input latency, for a pin change sampled at edge k:
  - sync2 updates at k+1, so a DATA read reflects the change after k+1
  - edge_capture sets at k+2
  - irq asserts after k+2 if the bit is masked in
- Writing IRQ_MASK or clearing EDGE_CAPTURE affects irq from the edge after the write.
- Pulses on in_port shorter than one clk period may be missed; this is not guaranteed.

## Configuration
- SYSTEM_GPIO_PIO_EDGE_IRQ_EN defined:
  - prev register, edge detect, EDGE_CAPTURE, IRQ_MASK and irq are built as described
- Undefined:
  - those elements are omitted
  - addresses 2 and 3 read 0 and ignore writes
  - irq tied to 0
  - DATA, DIRECTION, OUTSET, OUTCLEAR and the synchroniser are unchanged

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, oe_port=0, irq=0; read addr 4 = 32'h000000A5.
- Write DATA=32'hFFFF_FF3C, then OUTSET=8'h01, then OUTCLEAR=8'h0C -> out_port 8'h3C, then 8'h3D, then 8'h31; read addr 4 = 32'h31 with upper bits 0.
- EDGE_MODE=0, IRQ_MASK=8'h04; in_port bit2 0->1 at edge k -> EDGE_CAPTURE=8'h04 and irq=1 from k+2; write 8'h04 to addr 3 -> irq=0 next cycle.
- EDGE_MODE=2; toggle bit0 high then low, 5 cycles apart, with mask 0 -> EDGE_CAPTURE bit0 set, irq stays 0; then write IRQ_MASK=1 -> irq=1.
- New rising edge on bit1 in the same cycle as a write-1-to-clear of bit1 -> bit1 remains 1.
- Macro undefined: edge on in_port -> irq stays 0; reads of addr 2 and 3 return 0; DATA read returns in_port 2 cycles after the change.

Source files
------------

// File: rtl/system_gpio_pio.sv
// Avalon-MM GPIO slave: data/direction registers, atomic set/clear, synchronised inputs.
// Edge capture, IRQ mask and irq exist only when SYSTEM_GPIO_PIO_EDGE_IRQ_EN is defined.
module system_gpio_pio #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = |writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
        end else if (w_wr) begin
            case (address)
                3'd0:    r_data_out <= w_wdata;
                3'd4:    r_data_out <= r_data_out | w_wdata;
                3'd5:    r_data_out <= r_data_out & ~w_wdata;
                default: r_data_out <= r_data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir <= '0;
        end else if (w_wr && address == 3'd1) begin
            r_dir <= w_wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SYSTEM_GPIO_PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    always_comb begin
        w_edge = r_sync2 ^ r_prev;
        if (EDGE_MODE == 0) begin
            w_edge = r_sync2 & ~r_prev;
        end else if (EDGE_MODE == 1) begin
            w_edge = ~r_sync2 & r_prev;
        end
    end

    assign w_clr = (w_wr && address == 3'd3) ? w_wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_prev <= r_sync2;
            if (w_wr && address == 3'd2) begin
                r_mask <= w_wdata;
            end
            // A fresh edge outranks a same-cycle clear
            r_cap <= (r_cap & ~w_clr) | w_edge;
        end
    end

    assign irq = |(r_cap & r_mask);
`else
    logic [1:0] w_unused_mode;
    assign w_unused_mode = EDGE_MODE[1:0];
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (address)
            3'd0:    w_rd = r_sync2;
            3'd1:    w_rd = r_dir;
`ifdef SYSTEM_GPIO_PIO_EDGE_IRQ_EN
            3'd2:    w_rd = r_mask;
            3'd3:    w_rd = r_cap;
`endif
            3'd4:    w_rd = r_data_out;
            3'd5:    w_rd = r_data_out;
            default: w_rd = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = w_rd;
    end

    assign out_port = r_data_out;
    assign oe_port  = r_dir;

endmodule
